receptor_acciones_mascota: RTL and testbench
============================================

Name: receptor_acciones_mascota

Overview:
Consumer side of the COMIDA/SALUD button-action signals. It turns the `senal` outputs of the two button-action blocks into pet-stat updates. It also applies periodic decay and enforces a cooldown between accepted actions. It sits between the button-action blocks and the main pet state machine / display logic, and owns the food and health levels.

Parameters:
COUNT_DECAY, 50000, clock cycles between decay ticks (>=2)
COUNT_ESPERA, 50000, cooldown length in clock cycles after an accepted action (>=1)
MAX_NIVEL, 5, saturation ceiling of each level (1..7)
NIVEL_INICIAL, 3, level loaded on reset (<= MAX_NIVEL)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
senal_comida  input  1  food action signal from the button block; level, may stay high many cycles
senal_salud  input  1  health action signal from the button block; level, may stay high many cycles
nivel_comida  output  3  current food level, 0..MAX_NIVEL
nivel_salud  output  3  current health level, 0..MAX_NIVEL
estado  output  2  FSM state: 0 IDLE, 1 ALIMENTAR, 2 CURAR, 3 ESPERA
ocupado  output  1  high whenever estado != IDLE
fin_accion  output  1  one-cycle pulse when an action is applied
alerta  output  1  high when either level == 0
rechazo  output  1  one-cycle pulse on a dropped request (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - nivel_comida = nivel_salud = NIVEL_INICIAL.
  - estado = IDLE; ocupado = fin_accion = rechazo = 0.
  - alerta = 0 (given NIVEL_INICIAL > 0).
  - Decay and cooldown counters = 0; edge-detect registers = 0.
  - Reset asserted mid-action or mid-cooldown aborts with no level change.
- Edge detection:
  - Each senal_* is registered into prev_*.
  - Request = senal & ~prev: one request per rising edge. A held-high input never re-triggers.
- FSM:
  - IDLE: comida request -> ALIMENTAR. Salud request alone -> CURAR. Both in the same cycle -> ALIMENTAR; salud is dropped (rechazo pulse).
  - ALIMENTAR: exactly one cycle. fin_accion = 1 while in this state. Food increment is committed at the clock edge leaving the state. Next state ESPERA.
  - CURAR: same as ALIMENTAR, but increments health.
  - ESPERA: cooldown counter runs 0..COUNT_ESPERA-1, then the FSM returns to IDLE and the counter clears. Any request seen here is dropped (rechazo pulse) and never queued.
- Latency: senal rising before clock edge E.
  - estado = ALIMENTAR/CURAR after E+1.
  - New level visible after E+2.
  - IDLE re-entered after E+2+COUNT_ESPERA.
- Decay:
  - Free-running counter 0..COUNT_DECAY-1, independent of the FSM.
  - At the terminal count, both levels decrement by 1, saturating at 0.
- Level arithmetic, per level, per cycle:
  - Apply decrement (saturate at 0), then increment (saturate at MAX_NIVEL).
  - Simultaneous decay + food increment: 0 -> 1, MAX -> MAX, k -> k.
- alerta: registered; equals (nivel_comida == 0) | (nivel_salud == 0) one cycle after the levels change.
- All counters are $clog2-sized. No counter wraps except by its explicit terminal-count clear.

Optional Feature:
Macro RECHAZO_ACCION_EN.
- Defined: rechazo pulses high for one cycle on every dropped request:
  - a request during ESPERA, ALIMENTAR or CURAR;
  - the salud request lost to a simultaneous comida request.
- Not defined: rechazo is tied to 0 and no rechazo logic is synthesized. All other behaviour is identical.

Test Plan:
All tests use COUNT_DECAY=20, COUNT_ESPERA=8, MAX_NIVEL=5, NIVEL_INICIAL=3, reset released at cycle 2.
1. senal_comida high for 30 cycles starting at cycle 3 -> exactly one fin_accion pulse; nivel_comida 3->4; estado goes 1 then 3 for 8 cycles, then 0; nivel_salud unchanged (except decay).
2. senal_comida and senal_salud rise in the same cycle -> comida 3->4, salud stays 3. With RECHAZO_ACCION_EN: one rechazo pulse. Without it: rechazo stays 0.
3. No input for 80 cycles -> both levels step 3,2,1,0 at each 20-cycle tick and hold at 0; alerta rises one cycle after reaching 0.
4. Five food pulses spaced 12 cycles apart from level 3 -> nivel_comida saturates at 5, never exceeds 5. With a 12-cycle spacing, a rising edge inside ESPERA is dropped; check each accepted/dropped edge against the ESPERA window.
5. Food action applied in the same cycle as a decay tick at level 0 -> level becomes 1; at level 5 -> stays 5.
6. Reset asserted during ESPERA (cycle 4 of cooldown) -> estado, ocupado and the counters clear immediately (asynchronously); levels return to 3; a new comida edge after release is accepted normally.

Source files
------------

// File: rtl/receptor_acciones_mascota.sv
// rtl/receptor_acciones_mascota.sv - food/health action receiver with decay and cooldown
// Optional feature macro: RECHAZO_ACCION_EN (rechazo pulses on dropped requests; tied to 0 otherwise)
module receptor_acciones_mascota #(
  parameter int COUNT_DECAY   = 50000,
  parameter int COUNT_ESPERA  = 50000,
  parameter int MAX_NIVEL     = 5,
  parameter int NIVEL_INICIAL = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       senal_comida,
  input  logic       senal_salud,
  output logic [2:0] nivel_comida,
  output logic [2:0] nivel_salud,
  output logic [1:0] estado,
  output logic       ocupado,
  output logic       fin_accion,
  output logic       alerta,
  output logic       rechazo
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ALIMENTAR = 2'd1,
    CURAR     = 2'd2,
    ESPERA    = 2'd3
  } estado_t;

  localparam int DW = (COUNT_DECAY > 1) ? $clog2(COUNT_DECAY) : 1;
  localparam int EW = (COUNT_ESPERA > 1) ? $clog2(COUNT_ESPERA) : 1;
  localparam logic [DW-1:0] DECAY_TC  = DW'(COUNT_DECAY - 1);
  localparam logic [EW-1:0] ESPERA_TC = EW'(COUNT_ESPERA - 1);
  localparam logic [2:0]    MAX_L     = 3'(MAX_NIVEL);
  localparam logic [2:0]    INI_L     = 3'(NIVEL_INICIAL);

  estado_t       state, state_next;
  logic          sen_c_q, prev_c, sen_s_q, prev_s;
  logic          req_c, req_s;
  logic [DW-1:0] cnt_decay;
  logic [EW-1:0] cnt_espera;
  logic          decay_tick;

  // Decrement first (floor 0), then increment (ceiling MAX_L)
  function automatic logic [2:0] actualizar(input logic [2:0] nivel, input logic dec, input logic inc);
    logic [2:0] t;
    t = (dec && (nivel != 3'd0)) ? nivel - 3'd1 : nivel;
    if (inc && (t != MAX_L)) t = t + 3'd1;
    return t;
  endfunction

  // Sample the inputs once, then keep the previous sample for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sen_c_q <= 1'b0;
      prev_c  <= 1'b0;
      sen_s_q <= 1'b0;
      prev_s  <= 1'b0;
    end else begin
      sen_c_q <= senal_comida;
      prev_c  <= sen_c_q;
      sen_s_q <= senal_salud;
      prev_s  <= sen_s_q;
    end
  end

  assign req_c = sen_c_q & ~prev_c;
  assign req_s = sen_s_q & ~prev_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: comida wins a tie, requests outside IDLE are never queued
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_c)      state_next = ALIMENTAR;
        else if (req_s) state_next = CURAR;
      end
      ALIMENTAR: state_next = ESPERA;
      CURAR:     state_next = ESPERA;
      ESPERA: begin
        if (cnt_espera == ESPERA_TC) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cooldown counter only runs while in ESPERA and clears on the way out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_espera <= '0;
    end else if (state == ESPERA) begin
      if (cnt_espera == ESPERA_TC) cnt_espera <= '0;
      else                         cnt_espera <= cnt_espera + EW'(1);
    end else begin
      cnt_espera <= '0;
    end
  end

  // Free-running decay counter, independent of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt_decay <= '0;
    else if (cnt_decay == DECAY_TC) cnt_decay <= '0;
    else                            cnt_decay <= cnt_decay + DW'(1);
  end

  assign decay_tick = (cnt_decay == DECAY_TC);

  // Levels: increment committed on the edge leaving ALIMENTAR/CURAR, decay on terminal count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nivel_comida <= INI_L;
      nivel_salud  <= INI_L;
    end else begin
      nivel_comida <= actualizar(nivel_comida, decay_tick, state == ALIMENTAR);
      nivel_salud  <= actualizar(nivel_salud,  decay_tick, state == CURAR);
    end
  end

  // Alert follows the registered levels by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) alerta <= 1'b0;
    else       alerta <= (nivel_comida == 3'd0) || (nivel_salud == 3'd0);
  end

  assign estado     = state;
  assign ocupado    = (state != IDLE);
  assign fin_accion = (state == ALIMENTAR) || (state == CURAR);

`ifdef RECHAZO_ACCION_EN
  assign rechazo = ((state != IDLE) && (req_c || req_s)) ||
                   ((state == IDLE) && req_c && req_s);
`else
  assign rechazo = 1'b0;
`endif

endmodule

// File: tb/tb_receptor_acciones_mascota.sv
// tb/tb_receptor_acciones_mascota.sv - scoreboard bench for receptor_acciones_mascota
module tb_receptor_acciones_mascota;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       senal_comida = 1'b0;
  logic       senal_salud = 1'b0;
  logic [2:0] nivel_comida, nivel_salud;
  logic [1:0] estado;
  logic       ocupado, fin_accion, alerta, rechazo;

  typedef struct packed {
    logic [1:0] est;
    logic [2:0] c;
    logic [2:0] s;
  } exp_t;

  exp_t act_q[$];
  exp_t rej_q[$];
  int   tests = 0;
  int   fails = 0;

  receptor_acciones_mascota #(
    .COUNT_DECAY(20), .COUNT_ESPERA(8), .MAX_NIVEL(5), .NIVEL_INICIAL(3)
  ) dut (
    .clk(clk), .reset(reset),
    .senal_comida(senal_comida), .senal_salud(senal_salud),
    .nivel_comida(nivel_comida), .nivel_salud(nivel_salud),
    .estado(estado), .ocupado(ocupado), .fin_accion(fin_accion),
    .alerta(alerta), .rechazo(rechazo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    senal_comida = 1'b0;
    senal_salud  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic exp_t mk(input int est, input int c, input int s);
    exp_t e;
    e.est = 2'(est);
    e.c   = 3'(c);
    e.s   = 3'(s);
    return e;
  endfunction

  // Action monitor: each fin_accion pulse must match the next expected action
  always begin
    exp_t e;
    @(negedge clk);
    if (!reset && fin_accion) begin
      if (act_q.size() == 0) begin
        chk("unexpected_fin_accion", 1, 0);
      end else begin
        e = act_q.pop_front();
        chk("fin_estado", int'(estado), int'(e.est));
        @(negedge clk);
        chk("fin_nivel_comida", int'(nivel_comida), int'(e.c));
        chk("fin_nivel_salud", int'(nivel_salud), int'(e.s));
      end
    end
  end

  // Rejection monitor: each rechazo pulse must match the next expected drop
  always begin
    exp_t e;
    @(negedge clk);
    if (!reset && rechazo) begin
      if (rej_q.size() == 0) begin
        chk("unexpected_rechazo", 1, 0);
      end else begin
        e = rej_q.pop_front();
        chk("rechazo_estado", int'(estado), int'(e.est));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: held comida gives one action, cooldown timing, decay at edge 20
    do_reset();
    chk("rst_comida", int'(nivel_comida), 3);
    chk("rst_salud", int'(nivel_salud), 3);
    chk("rst_estado", int'(estado), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_fin", int'(fin_accion), 0);
    chk("rst_alerta", int'(alerta), 0);
    chk("rst_rechazo", int'(rechazo), 0);
    act_q.push_back(mk(1, 4, 3));
    senal_comida = 1'b1;
    step(2);  chk("t1_alimentar", int'(estado), 1);
    step(1);  chk("t1_espera_in", int'(estado), 3);
              chk("t1_ocupado", int'(ocupado), 1);
    step(7);  chk("t1_espera_end", int'(estado), 3);
    step(1);  chk("t1_idle", int'(estado), 0);
              chk("t1_ocupado_low", int'(ocupado), 0);
    step(10); chk("t1_decay_comida", int'(nivel_comida), 3);
              chk("t1_decay_salud", int'(nivel_salud), 2);
    step(9);
    senal_comida = 1'b0;
    step(5);

    // Test 2: simultaneous requests, comida wins
    do_reset();
    act_q.push_back(mk(1, 4, 3));
`ifdef RECHAZO_ACCION_EN
    rej_q.push_back(mk(0, 0, 0));
`endif
    senal_comida = 1'b1;
    senal_salud  = 1'b1;
    step(4);  chk("t2_comida", int'(nivel_comida), 4);
              chk("t2_salud", int'(nivel_salud), 3);
    senal_comida = 1'b0;
    senal_salud  = 1'b0;
    step(12); chk("t2_idle", int'(estado), 0);

    // Test 3: pure decay down to 0 and alert
    do_reset();
    step(19); chk("t3_pre_decay", int'(nivel_comida), 3);
    step(1);  chk("t3_c2", int'(nivel_comida), 2);
              chk("t3_s2", int'(nivel_salud), 2);
    step(20); chk("t3_c1", int'(nivel_comida), 1);
              chk("t3_s1", int'(nivel_salud), 1);
    step(20); chk("t3_c0", int'(nivel_comida), 0);
              chk("t3_s0", int'(nivel_salud), 0);
              chk("t3_alerta_lag", int'(alerta), 0);
    step(1);  chk("t3_alerta", int'(alerta), 1);
    step(19); chk("t3_hold_c", int'(nivel_comida), 0);
              chk("t3_hold_s", int'(nivel_salud), 0);
              chk("t3_alerta_hold", int'(alerta), 1);

    // Test 4: five spaced pulses saturate at 5, plus one edge inside ESPERA
    do_reset();
    act_q.push_back(mk(1, 4, 3));
    act_q.push_back(mk(1, 5, 3));
    act_q.push_back(mk(1, 5, 2));
    act_q.push_back(mk(1, 5, 2));
    act_q.push_back(mk(1, 5, 1));
`ifdef RECHAZO_ACCION_EN
    rej_q.push_back(mk(3, 0, 0));
`endif
    for (int i = 0; i < 4; i++) begin
      senal_comida = 1'b1;
      step(2);
      senal_comida = 1'b0;
      step(10);
    end
    senal_comida = 1'b1;
    step(2);
    senal_comida = 1'b0;
    step(4);
    senal_comida = 1'b1;
    step(2);
    senal_comida = 1'b0;
    step(2);  chk("t4_espera", int'(estado), 3);
    step(1);  chk("t4_idle", int'(estado), 0);
    step(3);  chk("t4_comida", int'(nivel_comida), 4);
              chk("t4_salud", int'(nivel_salud), 0);

    // Test 5a: action commit coincides with decay at level 0
    do_reset();
    act_q.push_back(mk(1, 1, 0));
    step(77);
    senal_comida = 1'b1;
    step(2);
    senal_comida = 1'b0;
    step(1);  chk("t5_zero_comida", int'(nivel_comida), 1);
              chk("t5_zero_salud", int'(nivel_salud), 0);
    step(12);

    // Test 5b: action commit coincides with decay at level 5
    do_reset();
    act_q.push_back(mk(1, 4, 3));
    act_q.push_back(mk(1, 5, 3));
    act_q.push_back(mk(1, 5, 2));
    act_q.push_back(mk(1, 5, 1));
    senal_comida = 1'b1; step(2);
    senal_comida = 1'b0; step(10);
    senal_comida = 1'b1; step(2);
    senal_comida = 1'b0; step(10);
    senal_comida = 1'b1; step(2);
    senal_comida = 1'b0; step(11);
    senal_comida = 1'b1; step(2);
    senal_comida = 1'b0; step(1);
    chk("t5_max_comida", int'(nivel_comida), 5);
    chk("t5_max_salud", int'(nivel_salud), 1);
    step(10);

    // Test 6: async reset during cooldown, then a fresh action
    do_reset();
    act_q.push_back(mk(1, 4, 3));
    senal_comida = 1'b1;
    step(6);  chk("t6_espera", int'(estado), 3);
              chk("t6_comida_pre", int'(nivel_comida), 4);
    senal_comida = 1'b0;
    reset = 1'b1;
    #2;
    chk("t6_async_estado", int'(estado), 0);
    chk("t6_async_ocupado", int'(ocupado), 0);
    chk("t6_async_comida", int'(nivel_comida), 3);
    chk("t6_async_salud", int'(nivel_salud), 3);
    do_reset();
    act_q.push_back(mk(1, 4, 3));
    senal_comida = 1'b1;
    step(3);  chk("t6_new_comida", int'(nivel_comida), 4);
    step(8);  chk("t6_new_idle", int'(estado), 0);
    senal_comida = 1'b0;
    step(4);

    chk("act_queue_empty", act_q.size(), 0);
    chk("rej_queue_empty", rej_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
